// File: rtl/nand_reliability_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nand_reliability_pkg
//  Description : Shared types and helpers for the NAND-bundle voter block.
//  Revision    : 1.0  initial release
// ============================================================================
package nand_reliability_pkg;

    // Measurement controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } voter_state_e;

    // Bits needed to hold a popcount of n wires (0..n inclusive)
    function automatic int pop_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bundle_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : bundle_popcount
//  Description : Combinational count of asserted wires in a NAND bundle.
//  Revision    : 1.0  initial release
// ============================================================================
module bundle_popcount
    import nand_reliability_pkg::*;
#(
    parameter int N_WIRES = 5,
    parameter int POP_W   = pop_width(N_WIRES)
) (
    input  logic [N_WIRES-1:0] i_bundle,
    output logic [POP_W-1:0]   o_pop
);

    // Ripple sum of the individual wire bits
    always_comb begin
        o_pop = '0;
        for (int i = 0; i < N_WIRES; i++) begin
            o_pop = o_pop + POP_W'(i_bundle[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/nand_bundle_voter.sv
`default_nettype none
// ============================================================================
//  Module      : nand_bundle_voter
//  Description : Majority-vote restoration of an N-wire NAND bundle with
//                windowed error-rate counters (voted and per-wire).
//                Optional macro VOTER_WIRE_ERR_EN builds the per-wire
//                mismatch accumulator; otherwise wire_err_cnt_o reads 0.
//  Revision    : 1.0  initial release
// ============================================================================
module nand_bundle_voter
    import nand_reliability_pkg::*;
#(
    parameter int N_WIRES = 5,
    parameter int WINDOW  = 1000,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_WIRES-1:0] bundle_i,
    input  logic               golden_i,
    input  logic               sample_en_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               voted_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   sample_cnt_o,
    output logic [CNT_W-1:0]   voted_err_cnt_o,
    output logic [CNT_W-1:0]   wire_err_cnt_o
);

    localparam int               POP_W     = pop_width(N_WIRES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_WINDOW  = CNT_W'(WINDOW);
    localparam logic [POP_W-1:0] C_HALF    = POP_W'(N_WIRES / 2);

    if ((N_WIRES < 3) || ((N_WIRES % 2) == 0)) begin : g_bad_n_wires
        $error("nand_bundle_voter: N_WIRES must be odd and >= 3");
    end
    if ((WINDOW < 1) || (WINDOW > ((2 ** CNT_W) - 1))) begin : g_bad_window
        $error("nand_bundle_voter: WINDOW must be in 1 .. 2**CNT_W-1");
    end

    logic [POP_W-1:0] w_pop;
    logic             r_voted;
    logic             r_golden;
    logic             r_sample;
    voter_state_e     r_state;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_voted_err;
    logic [CNT_W-1:0] w_sample_nxt;
    logic [CNT_W-1:0] w_voted_nxt;
    logic             w_clear;
    logic             w_accum;

    bundle_popcount #(
        .N_WIRES (N_WIRES),
        .POP_W   (POP_W)
    ) u_popcount (
        .i_bundle (bundle_i),
        .o_pop    (w_pop)
    );

    // Stage 1: register the vote and the aligned golden/sample qualifiers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_voted  <= 1'b0;
            r_golden <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_voted  <= (w_pop > C_HALF);
            r_golden <= golden_i;
            r_sample <= sample_en_i;
        end
    end

    // Abort dominates start; start only clears outside RUN
    assign w_clear = !abort_i && start_i && (r_state != RUN);
    assign w_accum = (r_state == RUN) && !abort_i && r_sample;

    // Saturating next values for the always-present counters
    assign w_sample_nxt = (r_sample_cnt == C_CNT_MAX) ? r_sample_cnt : r_sample_cnt + C_ONE;
    assign w_voted_nxt  = ((r_voted_err == C_CNT_MAX) || (r_voted == r_golden))
                          ? r_voted_err : r_voted_err + C_ONE;

    // Window controller and the sample / voted-error counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_voted_err  <= '0;
        end else begin
            if (w_clear) begin
                r_sample_cnt <= '0;
                r_voted_err  <= '0;
            end else if (w_accum) begin
                r_sample_cnt <= w_sample_nxt;
                r_voted_err  <= w_voted_nxt;
            end
            case (r_state)
                IDLE: if (w_clear) r_state <= RUN;
                RUN: begin
                    if (abort_i)
                        r_state <= IDLE;
                    else if (w_accum && (w_sample_nxt == C_WINDOW))
                        r_state <= DONE;
                end
                DONE: begin
                    if (abort_i)
                        r_state <= IDLE;
                    else if (start_i)
                        r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VOTER_WIRE_ERR_EN
    logic [POP_W-1:0] r_pop;
    logic [POP_W-1:0] w_wire_inc;
    logic [CNT_W:0]   w_wire_sum;
    logic [CNT_W-1:0] r_wire_err;

    // Mismatching wires this sample: zeros when golden is 1, ones otherwise
    assign w_wire_inc = r_golden ? (POP_W'(N_WIRES) - r_pop) : r_pop;
    assign w_wire_sum = {1'b0, r_wire_err} + (CNT_W + 1)'(w_wire_inc);

    // Registered popcount and saturating per-wire mismatch accumulator
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pop      <= '0;
            r_wire_err <= '0;
        end else begin
            r_pop <= w_pop;
            if (w_clear)
                r_wire_err <= '0;
            else if (w_accum)
                r_wire_err <= w_wire_sum[CNT_W] ? C_CNT_MAX : w_wire_sum[CNT_W-1:0];
        end
    end

    assign wire_err_cnt_o = r_wire_err;
`else
    assign wire_err_cnt_o = '0;
`endif

    assign voted_o         = r_voted;
    assign busy_o          = (r_state == RUN);
    assign done_o          = (r_state == DONE);
    assign sample_cnt_o    = r_sample_cnt;
    assign voted_err_cnt_o = r_voted_err;

endmodule
`default_nettype wire

// File: tb/tb_nand_bundle_voter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nand_bundle_voter
//  Description : Self-checking bench for nand_bundle_voter: directed cases
//                plus randomized bundles against a behavioural model, on a
//                WINDOW=8 instance and a narrow saturating CNT_W=4 instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nand_bundle_voter;

`ifdef VOTER_WIRE_ERR_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    typedef struct {
        int mode;     // 0 idle, 1 measuring, 2 window complete
        int cnt;
        int verr;
        int werr;
        bit pvoted;
        int ppop;
        bit pgold;
        bit psamp;
    } model_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] bundle;
    logic       golden, sample_en, start, abort;

    logic        d1_voted, d1_busy, d1_done;
    logic [15:0] d1_cnt, d1_verr, d1_werr;
    logic        d2_voted, d2_busy, d2_done;
    logic [3:0]  d2_cnt, d2_verr, d2_werr;

    int     checks = 0;
    int     errors = 0;
    bit     chk_on = 1'b0;
    model_t m1, m2;

    always #5 clk = ~clk;

    nand_bundle_voter #(.N_WIRES(5), .WINDOW(8), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .golden_i(golden),
        .sample_en_i(sample_en), .start_i(start), .abort_i(abort),
        .voted_o(d1_voted), .busy_o(d1_busy), .done_o(d1_done),
        .sample_cnt_o(d1_cnt), .voted_err_cnt_o(d1_verr), .wire_err_cnt_o(d1_werr)
    );

    nand_bundle_voter #(.N_WIRES(5), .WINDOW(15), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .golden_i(golden),
        .sample_en_i(sample_en), .start_i(start), .abort_i(abort),
        .voted_o(d2_voted), .busy_o(d2_busy), .done_o(d2_done),
        .sample_cnt_o(d2_cnt), .voted_err_cnt_o(d2_verr), .wire_err_cnt_o(d2_werr)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: what the outputs must read after one clock edge
    function automatic model_t step(input model_t m, input bit rn, input logic [4:0] b,
                                    input bit g, input bit se, input bit st, input bit ab,
                                    input int win, input int maxv);
        model_t r;
        int     wrong;
        r = m;
        if (!rn) begin
            r = '{default: 0};
            return r;
        end
        case (m.mode)
            0: if (st && !ab) begin
                r.mode = 1; r.cnt = 0; r.verr = 0; r.werr = 0;
            end
            1: if (ab) begin
                r.mode = 0;
            end else if (m.psamp) begin
                r.cnt = (m.cnt + 1 > maxv) ? maxv : m.cnt + 1;
                if (m.pvoted != m.pgold)
                    r.verr = (m.verr + 1 > maxv) ? maxv : m.verr + 1;
                if (WE) begin
                    wrong  = m.pgold ? 5 - m.ppop : m.ppop;
                    r.werr = (m.werr + wrong > maxv) ? maxv : m.werr + wrong;
                end
                if (r.cnt == win) r.mode = 2;
            end
            2: if (ab) begin
                r.mode = 0;
            end else if (st) begin
                r.mode = 1; r.cnt = 0; r.verr = 0; r.werr = 0;
            end
            default: r.mode = 0;
        endcase
        r.ppop   = $countones(b);
        r.pvoted = (r.ppop > 2);
        r.pgold  = g;
        r.psamp  = se;
        return r;
    endfunction

    // Advance both models on the same edge the DUTs see
    always @(posedge clk) begin
        m1 = step(m1, reset_n, bundle, golden, sample_en, start, abort, 8, 65535);
        m2 = step(m2, reset_n, bundle, golden, sample_en, start, abort, 15, 15);
    end

    // Compare every output of both instances mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            check("d1_voted", int'(d1_voted), int'(m1.pvoted));
            check("d1_busy",  int'(d1_busy),  int'(m1.mode == 1));
            check("d1_done",  int'(d1_done),  int'(m1.mode == 2));
            check("d1_cnt",   int'(d1_cnt),   m1.cnt);
            check("d1_verr",  int'(d1_verr),  m1.verr);
            check("d1_werr",  int'(d1_werr),  m1.werr);
            check("d2_voted", int'(d2_voted), int'(m2.pvoted));
            check("d2_busy",  int'(d2_busy),  int'(m2.mode == 1));
            check("d2_done",  int'(d2_done),  int'(m2.mode == 2));
            check("d2_cnt",   int'(d2_cnt),   m2.cnt);
            check("d2_verr",  int'(d2_verr),  m2.verr);
            check("d2_werr",  int'(d2_werr),  m2.werr);
        end
    end

    task automatic cyc(input logic [4:0] b, input bit g, input bit se, input bit st, input bit ab);
        bundle = b; golden = g; sample_en = se; start = st; abort = ab;
        @(negedge clk);
    endtask

    task automatic check_d1(input string tag, input int busy, input int done,
                            input int cnt, input int verr, input int werr);
        check({tag, "_busy"}, int'(d1_busy), busy);
        check({tag, "_done"}, int'(d1_done), done);
        check({tag, "_cnt"},  int'(d1_cnt),  cnt);
        check({tag, "_verr"}, int'(d1_verr), verr);
        check({tag, "_werr"}, int'(d1_werr), werr);
    endtask

    initial begin
        reset_n = 1'b0;
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_on = 1'b1;
        check("rst_voted", int'(d1_voted), 0);
        check_d1("rst", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Majority vote, one cycle of latency
        cyc(5'b00111, 1'b1, 1'b1, 1'b0, 1'b0);
        check("vote_00111", int'(d1_voted), 1);
        cyc(5'b00011, 1'b1, 1'b1, 1'b0, 1'b0);
        check("vote_00011", int'(d1_voted), 0);

        // Clean window of eight samples
        cyc(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clean_busy_before_last", int'(d1_busy), 1);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        check_d1("clean", 0, 1, 8, 0, 0);

        // Two wrong wires per sample: vote still correct
        cyc(5'b00011, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) cyc(5'b00011, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        check_d1("two_bad", 0, 1, 8, 0, WE ? 16 : 0);

        // Three wrong wires per sample: vote flips
        cyc(5'b00111, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) cyc(5'b00111, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'b00111, 1'b0, 1'b0, 1'b0, 1'b0);
        check_d1("three_bad", 0, 1, 8, 8, WE ? 24 : 0);

        // Gapped sampling, then abort keeps partial results
        cyc(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_cnt_1", int'(d1_cnt), 1);
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b1);
        check_d1("abort", 0, 0, 3, 0, 0);

        // start ignored while running; start+abort aborts
        cyc(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0);
        check_d1("start_in_run", 1, 0, 3, 0, 0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b1, 1'b1);
        check_d1("start_abort", 0, 0, 3, 0, 0);

        // Reset in the middle of a window with errors accumulated
        cyc(5'b00000, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_verr", int'(d1_verr), 3);
        reset_n = 1'b0;
        cyc(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_rst_voted", int'(d1_voted), 0);
        check_d1("mid_rst", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Narrow instance: every wire wrong saturates the 4-bit accumulator
        cyc(5'b00000, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (15) cyc(5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_done", int'(d2_done), 1);
        check("sat_cnt",  int'(d2_cnt),  15);
        check("sat_verr", int'(d2_verr), 15);
        check("sat_werr", int'(d2_werr), WE ? 15 : 0);

        // Randomized traffic: each wire flips away from golden with ~20% odds
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            bit         g;
            g = 1'($urandom_range(0, 1));
            for (int w = 0; w < 5; w++)
                b[w] = ($urandom_range(0, 99) < 20) ? !g : g;
            reset_n = ($urandom_range(0, 199) != 0);
            cyc(b, g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 99) < 2));
        end
        reset_n = 1'b1;
        cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
